// File: rtl/guess_game_ctrl.sv
// Game-level sequencer for the guess FSM: conditions the raw buttons,
// paces the FSM with a level-dependent step enable, and keeps score.
module guess_game_ctrl #(
   parameter int TICK_BASE = 25_000_000,
   parameter int TICK_STEP = 2_500_000,
   parameter int MAX_LEVEL = 7,
   parameter int DB_CYCLES = 500_000,
   parameter int LIVES     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   input  logic       start_raw,
   input  logic       fsm_win,
   input  logic       fsm_lose,
   output logic       fsm_en,
   output logic       fsm_reset,
   output logic [3:0] b_clean,
   output logic [2:0] level,
   output logic [7:0] wins,
   output logic [1:0] lives,
   output logic       game_over
);

   // Widths: prescaler spans the longest period, debounce counter spans DB_CYCLES.
   localparam int PW  = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
   localparam int DW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int NIN = 5;  // four guess buttons plus start

   localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
   localparam logic [2:0]    LEVEL_TOP = 3'(MAX_LEVEL);
   localparam logic [1:0]    LIVES_INI = 2'(LIVES);

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      WIN_HOLD,
      LOSE_HOLD,
      OVER
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [NIN-1:0] raw_in;
   logic [NIN-1:0] sync1_reg;
   logic [NIN-1:0] sync2_reg;
   logic [NIN-1:0] db_reg;

   assign raw_in = {start_raw, btn_raw};

   // Two-flop synchronizer for every raw input bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= raw_in;
         sync2_reg <= sync1_reg;
      end
   end

   // Per-bit debouncer: the clean value only follows the synced value once
   // it has disagreed for DB_CYCLES consecutive cycles.
   genvar gi;
   generate
      for (gi = 0; gi < NIN; gi++) begin : g_db
         logic [DW-1:0] cnt_reg;

         // Stability counter and debounced flop for one input bit.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg    <= '0;
               db_reg[gi] <= 1'b0;
            end else if (sync2_reg[gi] == db_reg[gi]) begin
               cnt_reg <= '0;
            end else if (cnt_reg == DB_LAST) begin
               cnt_reg    <= '0;
               db_reg[gi] <= ~db_reg[gi];
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   endgenerate

   assign b_clean = db_reg[3:0];

   // ------------------------------------------------------------------
   // Edge detection
   // ------------------------------------------------------------------
   logic start_prev_reg;
   logic win_prev_reg;
   logic lose_prev_reg;
   logic start_pulse;
   logic win_rise;
   logic lose_rise;

   // Previous-value registers for the start button and the FSM flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_prev_reg <= 1'b0;
         win_prev_reg   <= 1'b0;
         lose_prev_reg  <= 1'b0;
      end else begin
         start_prev_reg <= db_reg[4];
         win_prev_reg   <= fsm_win;
         lose_prev_reg  <= fsm_lose;
      end
   end

   assign start_pulse = db_reg[4] & ~start_prev_reg;
   assign win_rise    = fsm_win & ~win_prev_reg;
   assign lose_rise   = fsm_lose & ~lose_prev_reg;

   // ------------------------------------------------------------------
   // Game state and scoring
   // ------------------------------------------------------------------
   state_t        state_reg,  state_next;
   logic [2:0]    level_reg,  level_next;
   logic [7:0]    wins_reg,   wins_next;
   logic [1:0]    lives_reg,  lives_next;
   logic [PW-1:0] presc_reg,  presc_next;
   logic          fsm_reset_reg;

   logic [31:0]   period;
   logic          presc_hit;
   logic          counting;

   // Step period shrinks with level; >= keeps a mid-count shortening safe.
   assign period    = 32'(TICK_BASE) - (32'(level_reg) * 32'(TICK_STEP));
   assign presc_hit = (32'(presc_reg) >= (period - 32'd1));
   assign counting  = (state_reg == PLAY) || (state_reg == WIN_HOLD) ||
                      (state_reg == LOSE_HOLD);

   // State, score and prescaler registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         level_reg <= '0;
         wins_reg  <= '0;
         lives_reg <= '0;
         presc_reg <= '0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
         wins_reg  <= wins_next;
         lives_reg <= lives_next;
         presc_reg <= presc_next;
      end
   end

   // The guess FSM is held in reset while no game is running; registered so
   // it releases one cycle after play starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_reset_reg <= 1'b1;
      end else begin
         fsm_reset_reg <= (state_reg == IDLE) || (state_reg == OVER);
      end
   end

   // Next-state, scoring and step-enable logic.
   always_comb begin
      state_next = state_reg;
      level_next = level_reg;
      wins_next  = wins_reg;
      lives_next = lives_reg;
      presc_next = presc_reg;
      fsm_en     = 1'b0;

      if (counting) begin
         if (presc_hit) begin
            fsm_en     = 1'b1;
            presc_next = '0;
         end else begin
            presc_next = presc_reg + 1'b1;
         end
      end

      case (state_reg)
         IDLE, OVER: begin
            // Score is frozen for display; a new start reloads everything.
            presc_next = '0;
            if (start_pulse) begin
               state_next = PLAY;
               lives_next = LIVES_INI;
               level_next = '0;
               wins_next  = '0;
            end
         end

         PLAY: begin
            if (win_rise) begin
               if (wins_reg != 8'hFF) begin
                  wins_next = wins_reg + 8'd1;
               end
               if (level_reg < LEVEL_TOP) begin
                  level_next = level_reg + 3'd1;
               end
               state_next = WIN_HOLD;
            end else if (lose_rise) begin
               lives_next = lives_reg - 2'd1;
               if (lives_reg <= 2'd1) begin
                  lives_next = '0;
                  state_next = OVER;
               end else begin
                  state_next = LOSE_HOLD;
               end
            end
         end

         WIN_HOLD, LOSE_HOLD: begin
            // Wait for the FSM to drop both flags before scoring again.
            if (!fsm_win && !fsm_lose) begin
               state_next = PLAY;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign fsm_reset = fsm_reset_reg;
   assign level     = level_reg;
   assign wins      = wins_reg;
   assign lives     = lives_reg;
   assign game_over = (state_reg == OVER);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl with shortened timing parameters.
module tb_guess_game_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] btn_raw;
   logic       start_raw;
   logic       fsm_win;
   logic       fsm_lose;
   logic       fsm_en;
   logic       fsm_reset;
   logic [3:0] b_clean;
   logic [2:0] level;
   logic [7:0] wins;
   logic [1:0] lives;
   logic       game_over;

   int checks   = 0;
   int failures = 0;

   guess_game_ctrl #(
      .TICK_BASE(10),
      .TICK_STEP(2),
      .MAX_LEVEL(3),
      .DB_CYCLES(4),
      .LIVES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .start_raw(start_raw),
      .fsm_win(fsm_win),
      .fsm_lose(fsm_lose),
      .fsm_en(fsm_en),
      .fsm_reset(fsm_reset),
      .b_clean(b_clean),
      .level(level),
      .wins(wins),
      .lives(lives),
      .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic win;
      logic lose;
      int   exp_wins;
      int   exp_level;
      int   exp_lives;
      logic exp_over;
      int   exp_period;  // 0 means fsm_en must stay silent
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Ticks until fsm_en is seen; n is the number of ticks taken (capped).
   task automatic wait_en(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!fsm_en && n < 200);
   endtask

   initial begin
      int n;
      int cnt;
      int bad;

      vecs[0] = '{1'b1, 1'b0, 1, 1, 2, 1'b0, 8};
      vecs[1] = '{1'b1, 1'b0, 2, 2, 2, 1'b0, 6};
      vecs[2] = '{1'b1, 1'b0, 3, 3, 2, 1'b0, 4};
      vecs[3] = '{1'b1, 1'b0, 4, 3, 2, 1'b0, 4};
      vecs[4] = '{1'b1, 1'b1, 5, 3, 2, 1'b0, 4};   // win beats lose
      vecs[5] = '{1'b0, 1'b1, 5, 3, 1, 1'b0, 4};
      vecs[6] = '{1'b0, 1'b1, 5, 3, 0, 1'b1, 0};   // last life -> OVER

      reset     = 1'b1;
      btn_raw   = 4'h0;
      start_raw = 1'b0;
      fsm_win   = 1'b0;
      fsm_lose  = 1'b0;
      repeat (3) tick();
      chk("rst_fsm_reset", fsm_reset, 1);
      chk("rst_fsm_en", fsm_en, 0);
      chk("rst_lives", lives, 0);
      chk("rst_game_over", game_over, 0);
      reset = 1'b0;
      tick();

      // Idle for 100 cycles: FSM held in reset, no steps.
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (fsm_en || !fsm_reset) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Start press: PLAY 7 cycles after the raw edge, fsm_reset drops one later.
      start_raw = 1'b1;
      repeat (6) tick();
      chk("start_t6_lives", lives, 0);
      tick();
      chk("start_t7_lives", lives, 2);
      chk("start_t7_fsm_reset", fsm_reset, 1);
      tick();
      chk("start_t8_fsm_reset", fsm_reset, 0);
      repeat (2) tick();
      start_raw = 1'b0;
      wait_en(n);
      chk("first_en_delay", n, 6);
      wait_en(n);
      chk("en_period_l0", n, 10);

      // Button debounce: short glitch rejected, sustained press accepted.
      btn_raw[0] = 1'b1;
      repeat (3) tick();
      btn_raw[0] = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (b_clean[0]) bad++;
      end
      chk("glitch_rejected", bad, 0);
      btn_raw[0] = 1'b1;
      repeat (5) tick();
      chk("db_t5", b_clean[0], 0);
      tick();
      chk("db_t6", b_clean[0], 1);
      btn_raw[0] = 1'b0;
      repeat (10) tick();
      chk("db_release", b_clean[0], 0);

      // Table of win/lose events with resulting score and step period.
      for (int v = 0; v < 7; v++) begin
         fsm_win  = vecs[v].win;
         fsm_lose = vecs[v].lose;
         tick();
         chk($sformatf("v%0d_wins", v), wins, vecs[v].exp_wins);
         chk($sformatf("v%0d_level", v), level, vecs[v].exp_level);
         chk($sformatf("v%0d_lives", v), lives, vecs[v].exp_lives);
         chk($sformatf("v%0d_game_over", v), game_over, int'(vecs[v].exp_over));
         fsm_win  = 1'b0;
         fsm_lose = 1'b0;
         tick();
         chk($sformatf("v%0d_fsm_reset", v), fsm_reset, int'(vecs[v].exp_over));
         if (vecs[v].exp_period != 0) begin
            wait_en(n);
            wait_en(n);
            chk($sformatf("v%0d_period", v), n, vecs[v].exp_period);
         end else begin
            cnt = 0;
            for (int i = 0; i < 30; i++) begin
               tick();
               if (fsm_en) cnt++;
            end
            chk($sformatf("v%0d_en_silent", v), cnt, 0);
         end
      end

      // Restart from OVER: fresh load, game_over clears when PLAY is entered.
      start_raw = 1'b1;
      repeat (6) tick();
      chk("restart_t6_game_over", game_over, 1);
      tick();
      chk("restart_game_over", game_over, 0);
      chk("restart_lives", lives, 2);
      chk("restart_wins", wins, 0);
      chk("restart_level", level, 0);
      start_raw = 1'b0;
      repeat (10) tick();
      chk("restart_fsm_reset", fsm_reset, 0);

      // Held win: counted once, steps continue, one-cycle drop re-arms it.
      fsm_win = 1'b1;
      tick();
      chk("hold_wins_first", wins, 1);
      cnt = 0;
      for (int i = 0; i < 49; i++) begin
         tick();
         if (fsm_en) cnt++;
      end
      chk("hold_wins_held", wins, 1);
      chk("hold_en_pulsing", int'(cnt >= 5), 1);
      fsm_win = 1'b0;
      tick();
      chk("hold_drop_wins", wins, 1);
      fsm_win = 1'b1;
      tick();
      chk("hold_rewin_wins", wins, 2);
      fsm_win = 1'b0;
      repeat (3) tick();

      // Start pressed mid-game is ignored.
      start_raw = 1'b1;
      repeat (10) tick();
      chk("midgame_start_wins", wins, 2);
      chk("midgame_start_lives", lives, 2);
      start_raw = 1'b0;
      repeat (10) tick();

      // Asynchronous reset between clock edges.
      btn_raw = 4'b1010;
      repeat (7) tick();
      chk("pre_rst_b_clean", b_clean, 10);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async_b_clean", b_clean, 0);
      chk("async_level", level, 0);
      chk("async_wins", wins, 0);
      chk("async_lives", lives, 0);
      chk("async_game_over", game_over, 0);
      chk("async_fsm_reset", fsm_reset, 1);
      chk("async_fsm_en", fsm_en, 0);
      btn_raw = 4'h0;
      #1;
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (fsm_en || !fsm_reset) bad++;
      end
      chk("post_rst_idle", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
